// File: rtl/e_scale_param_buffer_pkg.sv
// Shared sizes and read-FSM encoding for the E_scale parameter ping-pong buffer.
package e_scale_param_buffer_pkg;

  localparam int SA_ROW_NUM = 4;
  localparam int ROW_NUM    = 16;
  localparam int PE_PAR     = 2;
  localparam int TAIL_W     = 16;
  localparam int RANK_W     = 8;

  localparam int SETS_NUM   = SA_ROW_NUM * ROW_NUM;
  localparam int SET_W      = PE_PAR * (TAIL_W + RANK_W);
  localparam int TAIL_SET_W = PE_PAR * TAIL_W;
  localparam int RANK_SET_W = PE_PAR * RANK_W;
  localparam int PTR_W      = $clog2(SETS_NUM);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SETS_NUM - 1);

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_e;

endpackage

// File: rtl/e_scale_param_buffer_if.sv
// Load stream, readout controls, parameter outputs and status of the buffer.
// Handshake: a load word transfers on a rising clk edge where param_in_valid and
// param_in_ready are both 1; valid may be held while ready is low without loss.
interface e_scale_param_buffer_if
  import e_scale_param_buffer_pkg::*;
();
  logic                  param_in_valid;
  logic [SET_W-1:0]      param_in_data;
  logic                  param_in_ready;
  logic                  tile_start;
  logic                  rd_advance;
  logic [TAIL_SET_W-1:0] E_scale_tail_set;
  logic [RANK_SET_W-1:0] E_scale_rank_set;
  logic                  rd_valid;
  logic                  tile_done;
  logic [1:0]            banks_full;
  rd_state_e             rd_state;

  modport master (
    output param_in_valid, param_in_data, tile_start, rd_advance,
    input  param_in_ready, E_scale_tail_set, E_scale_rank_set,
           rd_valid, tile_done, banks_full, rd_state
  );

  modport slave (
    input  param_in_valid, param_in_data, tile_start, rd_advance,
    output param_in_ready, E_scale_tail_set, E_scale_rank_set,
           rd_valid, tile_done, banks_full, rd_state
  );
endinterface

// File: rtl/e_scale_param_bank.sv
// One bank: SETS_NUM x SET_W register array, one write port, one registered read port.
module e_scale_param_bank
  import e_scale_param_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [SET_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [SET_W-1:0] rd_data_o
);

  logic [SET_W-1:0] mem_q [SETS_NUM];
  logic [SET_W-1:0] rd_data_q;

  // Contents are never cleared; stale data is fenced off by the pointers and full flags.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/e_scale_param_buffer.sv
// Ping-pong store of per-channel requant parameters: one bank loads while the other is read out.
module e_scale_param_buffer
  import e_scale_param_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  e_scale_param_buffer_if.slave  bus
);

  logic [PTR_W-1:0] wr_ptr_q;
  logic             wr_bank_q;
  logic [1:0]       full_q, full_d;
  rd_state_e        rd_state_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             rd_bank_q;
  logic             rd_valid_q;
  logic             tile_done_q;
  logic             out_sel_q;

  logic             wr_fire, wr_last;
  logic             rd_start, rd_step, rd_last, rd_en;
  logic [PTR_W-1:0] rd_addr;
  logic [SET_W-1:0] rd_data0, rd_data1, rd_data;

  assign bus.param_in_ready = ~full_q[wr_bank_q];
  assign wr_fire = bus.param_in_valid & ~full_q[wr_bank_q];
  assign wr_last = wr_fire & (wr_ptr_q == LAST_PTR);

  // Start only looks at the registered flag, so a same-cycle last write is not seen yet.
  assign rd_start = (rd_state_q == RD_IDLE) & bus.tile_start & full_q[rd_bank_q];
  assign rd_step  = (rd_state_q == RD_ACTIVE) & bus.rd_advance & (rd_ptr_q != LAST_PTR);
  assign rd_last  = (rd_state_q == RD_ACTIVE) & bus.rd_advance & (rd_ptr_q == LAST_PTR);
  assign rd_en    = rd_start | rd_step;
  assign rd_addr  = rd_start ? '0 : rd_ptr_q + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (wr_fire) begin
      wr_ptr_q <= wr_last ? '0 : wr_ptr_q + PTR_W'(1);
      if (wr_last) wr_bank_q <= ~wr_bank_q;
    end
  end

  // The two sides never touch the same flag in one cycle: the bank being read is full,
  // so the write side cannot be filling it.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) full_q <= '0;
    else       full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q  <= RD_IDLE;
      rd_ptr_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      tile_done_q <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      if (rd_en) out_sel_q <= rd_bank_q;
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_start) begin
            rd_state_q <= RD_ACTIVE;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b1;
          end
        end
        RD_ACTIVE: begin
          if (rd_last) begin
            // Outputs keep the last set: E_Scale latches rank a cycle after tail.
            rd_state_q  <= RD_IDLE;
            rd_valid_q  <= 1'b0;
            tile_done_q <= 1'b1;
            rd_bank_q   <= ~rd_bank_q;
          end else if (rd_step) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  e_scale_param_bank u_bank0 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_fire & ~wr_bank_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.param_in_data),
    .rd_en_i   (rd_en & ~rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data0)
  );

  e_scale_param_bank u_bank1 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_fire & wr_bank_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.param_in_data),
    .rd_en_i   (rd_en & rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data1)
  );

  assign rd_data              = out_sel_q ? rd_data1 : rd_data0;
  assign bus.E_scale_tail_set = rd_data[TAIL_SET_W-1:0];
  assign bus.E_scale_rank_set = rd_data[SET_W-1:TAIL_SET_W];
  assign bus.rd_valid         = rd_valid_q;
  assign bus.tile_done        = tile_done_q;
  assign bus.banks_full       = full_q;
  assign bus.rd_state         = rd_state_q;

endmodule

// File: tb/tb_e_scale_param_buffer.sv
// Directed bench for the E_scale parameter ping-pong buffer.
module tb_e_scale_param_buffer;
  import e_scale_param_buffer_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [47:0] exp_q[$];

  e_scale_param_buffer_if bus ();

  e_scale_param_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.param_in_valid = 1'b0;
    bus.param_in_data  = '0;
    bus.tile_start     = 1'b0;
    bus.rd_advance     = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [47:0] mk_word(input int tag, input int idx);
    logic [7:0] t;
    logic [7:0] x;
    t = 8'(tag);
    x = 8'(idx);
    return {t, x, x ^ 8'h5A, t, ~x, x};
  endfunction

  // Driver: push n words (indices first..first+n-1) through the load handshake.
  task automatic load_words(input int tag, input int first, input int n);
    int cnt;
    for (int i = first; i < first + n; i++) begin
      bus.param_in_data  = mk_word(tag, i);
      bus.param_in_valid = 1'b1;
      cnt = 0;
      while (bus.param_in_ready !== 1'b1 && cnt < 300) begin
        step();
        cnt++;
      end
      checks++;
      if (cnt >= 300) begin
        errors++;
        $display("FAIL load_timeout: word %0d ready=%b, required 1 within 300 cycles", i, bus.param_in_ready);
        bus.param_in_valid = 1'b0;
        return;
      end
      exp_q.push_back(bus.param_in_data);
      step();
    end
    bus.param_in_valid = 1'b0;
  endtask

  // Driver + scoreboard: start a tile and consume it, advancing every (gap+1) cycles.
  task automatic read_tile(input int gap, input int bank);
    logic [47:0] w;
    w = '0;
    bus.tile_start = 1'b1;
    step();
    bus.tile_start = 1'b0;
    for (int i = 0; i < SETS_NUM; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: set %0d has no expected value", i);
        return;
      end
      w = exp_q.pop_front();
      for (int g = 0; g <= gap; g++) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.tile_done !== 1'b0 ||
            bus.E_scale_tail_set !== w[31:0] || bus.E_scale_rank_set !== w[47:32]) begin
          errors++;
          $display("FAIL read_set %0d cyc %0d: valid=%b done=%b tail=%h rank=%h, required valid=1 done=0 tail=%h rank=%h",
                   i, g, bus.rd_valid, bus.tile_done, bus.E_scale_tail_set, bus.E_scale_rank_set,
                   w[31:0], w[47:32]);
        end
        if (g == gap) bus.rd_advance = 1'b1;
        step();
        bus.rd_advance = 1'b0;
      end
    end
    checks++;
    if (bus.tile_done !== 1'b1 || bus.rd_valid !== 1'b0 || bus.banks_full[bank] !== 1'b0 ||
        bus.rd_state !== RD_IDLE || bus.E_scale_tail_set !== w[31:0] || bus.E_scale_rank_set !== w[47:32]) begin
      errors++;
      $display("FAIL tile_end: done=%b valid=%b full=%b state=%0d tail=%h rank=%h, required done=1 valid=0 full[%0d]=0 idle tail=%h rank=%h",
               bus.tile_done, bus.rd_valid, bus.banks_full, bus.rd_state, bus.E_scale_tail_set,
               bus.E_scale_rank_set, bank, w[31:0], w[47:32]);
    end
    step();
    checks++;
    if (bus.tile_done !== 1'b0) begin
      errors++;
      $display("FAIL tile_done_pulse: tile_done=%b, required 0 one cycle later", bus.tile_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.param_in_ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.tile_done !== 1'b0 ||
        bus.banks_full !== 2'b00 || bus.E_scale_tail_set !== 32'h0 || bus.E_scale_rank_set !== 16'h0 ||
        bus.rd_state !== RD_IDLE) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b done=%b full=%b tail=%h rank=%h state=%0d, required 1 0 0 00 0 0 idle",
               bus.param_in_ready, bus.rd_valid, bus.tile_done, bus.banks_full,
               bus.E_scale_tail_set, bus.E_scale_rank_set, bus.rd_state);
    end
    bus.rd_advance = 1'b1;
    step();
    bus.rd_advance = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_state !== RD_IDLE) begin
      errors++;
      $display("FAIL idle_advance: valid=%b state=%0d, required 0 idle", bus.rd_valid, bus.rd_state);
    end
  endtask

  task automatic test_load_readout();
    do_reset();
    load_words(1, 0, 64);
    checks++;
    if (bus.banks_full !== 2'b01 || bus.param_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_full: full=%b ready=%b, required 01 1", bus.banks_full, bus.param_in_ready);
    end
    read_tile(0, 0);
  endtask

  task automatic test_backpressure();
    logic [47:0] w;
    do_reset();
    load_words(2, 0, 128);
    w = mk_word(3, 0);
    bus.param_in_data  = w;
    bus.param_in_valid = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.param_in_ready !== 1'b0 || bus.banks_full !== 2'b11) begin
        errors++;
        $display("FAIL both_full: ready=%b full=%b, required 0 11", bus.param_in_ready, bus.banks_full);
      end
      step();
    end
    // Word 129 is taken on the edge right after tile_done, while valid stays high.
    read_tile(0, 0);
    bus.param_in_valid = 1'b0;
    checks++;
    if (bus.param_in_ready !== 1'b1 || bus.banks_full !== 2'b10) begin
      errors++;
      $display("FAIL freed_bank: ready=%b full=%b, required 1 10", bus.param_in_ready, bus.banks_full);
    end
    read_tile(0, 1);
    load_words(4, 1, 63);
    read_tile(0, 0);
  endtask

  task automatic test_start_without_full();
    do_reset();
    bus.tile_start = 1'b1;
    step();
    bus.tile_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.rd_state !== RD_IDLE) begin
        errors++;
        $display("FAIL start_empty: valid=%b state=%0d, required 0 idle", bus.rd_valid, bus.rd_state);
      end
      step();
    end
    load_words(5, 0, 63);
    bus.tile_start = 1'b1;
    step();
    bus.tile_start = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_state !== RD_IDLE || bus.banks_full !== 2'b00) begin
      errors++;
      $display("FAIL start_partial: valid=%b state=%0d full=%b, required 0 idle 00",
               bus.rd_valid, bus.rd_state, bus.banks_full);
    end
    load_words(5, 63, 1);
    read_tile(0, 0);
  endtask

  task automatic test_slow_advance();
    do_reset();
    load_words(6, 0, 64);
    read_tile(2, 0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_words(7, 0, 64);
    load_words(7, 64, 10);
    bus.tile_start = 1'b1;
    step();
    bus.tile_start = 1'b0;
    bus.rd_advance = 1'b1;
    for (int i = 0; i < 30; i++) step();
    bus.rd_advance = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.banks_full !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset: valid=%b full=%b, required 1 01", bus.rd_valid, bus.banks_full);
    end
    do_reset();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.param_in_ready !== 1'b1 || bus.banks_full !== 2'b00 ||
        bus.tile_done !== 1'b0 || bus.rd_state !== RD_IDLE) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b full=%b done=%b state=%0d, required 0 1 00 0 idle",
               bus.rd_valid, bus.param_in_ready, bus.banks_full, bus.tile_done, bus.rd_state);
    end
    load_words(8, 0, 64);
    checks++;
    if (bus.banks_full !== 2'b01) begin
      errors++;
      $display("FAIL reload_full: full=%b, required 01", bus.banks_full);
    end
    read_tile(0, 0);
  endtask

  task automatic test_last_write_start();
    logic [47:0] w;
    do_reset();
    load_words(9, 0, 63);
    w = mk_word(9, 63);
    bus.param_in_data  = w;
    bus.param_in_valid = 1'b1;
    bus.tile_start     = 1'b1;
    checks++;
    if (bus.param_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL last_write_ready: ready=%b, required 1", bus.param_in_ready);
    end
    exp_q.push_back(w);
    step();
    bus.param_in_valid = 1'b0;
    bus.tile_start     = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_state !== RD_IDLE || bus.banks_full !== 2'b01) begin
      errors++;
      $display("FAIL same_cycle_start: valid=%b state=%0d full=%b, required 0 idle 01",
               bus.rd_valid, bus.rd_state, bus.banks_full);
    end
    read_tile(0, 0);
  endtask

  initial begin
    test_reset();
    test_load_readout();
    test_backpressure();
    test_start_without_full();
    test_slow_advance();
    test_mid_reset();
    test_last_write_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
